// File: rtl/test_func_sched_if.sv
// Bundle of requester, datapath and result signals shared by the
// two-channel burst scheduler and whatever drives it.
interface test_func_sched_if #(
  parameter int DATA_W = 128
);
  logic              I_start;
  logic              I_req0;
  logic              I_req1;
  logic [DATA_W-1:0] I_data0;
  logic [DATA_W-1:0] I_data1;
  logic              I_dv0;
  logic              I_dv1;
  logic              O_gnt0;
  logic              O_gnt1;
  logic [DATA_W-1:0] O_dp_data;
  logic              O_dp_dv;
  logic [DATA_W-1:0] I_dp_data;
  logic              I_dp_dv;
  logic [DATA_W-1:0] O_res_data;
  logic              O_res_dv0;
  logic              O_res_dv1;
  logic              O_busy;
  logic              O_err;

  modport slave (
    input  I_start, I_req0, I_req1, I_data0, I_data1, I_dv0, I_dv1,
    input  I_dp_data, I_dp_dv,
    output O_gnt0, O_gnt1, O_dp_data, O_dp_dv,
    output O_res_data, O_res_dv0, O_res_dv1, O_busy, O_err
  );

  modport master (
    output I_start, I_req0, I_req1, I_data0, I_data1, I_dv0, I_dv1,
    output I_dp_data, I_dp_dv,
    input  O_gnt0, O_gnt1, O_dp_data, O_dp_dv,
    input  O_res_data, O_res_dv0, O_res_dv1, O_busy, O_err
  );
endinterface

// File: rtl/test_func_sched.sv
// Two-channel burst scheduler: grants one requester a fixed-length burst onto a
// shared datapath and routes the datapath results back to the burst owner.
module test_func_sched #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16,
  parameter int DP_LAT    = 1
) (
  input  logic               I_aclk,
  input  logic               I_arst_n,
  test_func_sched_if.slave   bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN);

  state_t            state_reg, state_next;
  logic              own_reg, own_next;
  logic              ptr_reg, ptr_next;
  logic [7:0]        cnt_reg, cnt_next;

  logic [1:0]        req;
  logic [1:0]        dv;
  logic [1:0]        gnt;
  logic [1:0]        stray;
  logic              accept;
  logic [DATA_W-1:0] beat_data;

  logic              dp_dv_reg;
  logic [DATA_W-1:0] dp_data_reg;
  logic [DP_LAT:0]   tag_vld_reg;
  logic [DP_LAT:0]   tag_own_reg;
  logic [1:0]        res_hit;
  logic [1:0]        res_dv_reg;
  logic [DATA_W-1:0] res_data_reg;
  logic              err_reg;
  logic              tag_mismatch;

  assign req = {bus.I_req1, bus.I_req0};
  assign dv  = {bus.I_dv1, bus.I_dv0};

  // Per-channel grant decode, stray-beat detection and result routing.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign gnt[gi]     = (state_reg == ST_BURST) && (own_reg == 1'(gi));
    assign stray[gi]   = dv[gi] && !gnt[gi];
    assign res_hit[gi] = bus.I_dp_dv && tag_vld_reg[DP_LAT]
                         && (tag_own_reg[DP_LAT] == 1'(gi));
  end

  assign accept    = (state_reg == ST_BURST) && dv[own_reg];
  assign beat_data = own_reg ? bus.I_data1 : bus.I_data0;

  // Result valid without a tag, or a tag with no result, is a protocol error.
  assign tag_mismatch = bus.I_dp_dv ^ tag_vld_reg[DP_LAT];

  always_comb begin
    state_next = state_reg;
    own_next   = own_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.I_start && (|req)) begin
          state_next = ST_BURST;
          own_next   = (&req) ? ptr_reg : req[1];
          cnt_next   = 8'd0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          if (cnt_reg + 8'd1 == LAST_CNT) begin
            cnt_next   = 8'd0;
            ptr_next   = ~own_reg;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge I_aclk or negedge I_arst_n) begin
    if (!I_arst_n) begin
      state_reg <= ST_IDLE;
      own_reg   <= 1'b0;
      ptr_reg   <= 1'b0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      own_reg   <= own_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Forwarded beat and its {valid, owner} tag enter the pipeline together.
  always_ff @(posedge I_aclk or negedge I_arst_n) begin
    if (!I_arst_n) begin
      dp_dv_reg   <= 1'b0;
      dp_data_reg <= '0;
      tag_vld_reg <= '0;
      tag_own_reg <= '0;
    end else begin
      dp_dv_reg <= accept;
      if (accept) begin
        dp_data_reg <= beat_data;
      end
      if (DP_LAT > 0) begin
        tag_vld_reg <= {tag_vld_reg[DP_LAT-1:0], accept};
        tag_own_reg <= {tag_own_reg[DP_LAT-1:0], own_reg};
      end else begin
        tag_vld_reg <= accept;
        tag_own_reg <= own_reg;
      end
    end
  end

  always_ff @(posedge I_aclk or negedge I_arst_n) begin
    if (!I_arst_n) begin
      res_dv_reg   <= 2'b00;
      res_data_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      res_dv_reg <= res_hit;
      if (bus.I_dp_dv) begin
        res_data_reg <= bus.I_dp_data;
      end
      if ((|stray) || tag_mismatch) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.O_gnt0     = gnt[0];
  assign bus.O_gnt1     = gnt[1];
  assign bus.O_dp_dv    = dp_dv_reg;
  assign bus.O_dp_data  = dp_data_reg;
  assign bus.O_res_dv0  = res_dv_reg[0];
  assign bus.O_res_dv1  = res_dv_reg[1];
  assign bus.O_res_data = res_data_reg;
  assign bus.O_busy     = (state_reg == ST_BURST);
  assign bus.O_err      = err_reg;

endmodule

// File: tb/tb_test_func_sched.sv
// Directed bench for test_func_sched with an inverting one-cycle datapath model.
module tb_test_func_sched;

  logic clk;
  logic arst_n;
  int   n_assert;
  int   n_fail;
  int   res0_cnt;
  int   res1_cnt;
  int   b0;
  int   b1;
  logic [127:0] last_dp;
  logic drv;
  logic eg0;
  logic eg1;

  test_func_sched_if #(.DATA_W(128)) bus ();

  test_func_sched #(
    .DATA_W(128),
    .BURST_LEN(16),
    .DP_LAT(1)
  ) dut (
    .I_aclk  (clk),
    .I_arst_n(arst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: bitwise inverter, one cycle of latency.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus.I_dp_dv   <= 1'b0;
      bus.I_dp_data <= '0;
    end else begin
      bus.I_dp_dv   <= bus.O_dp_dv;
      bus.I_dp_data <= ~bus.O_dp_data;
    end
  end

  initial begin
    res0_cnt = 0;
    res1_cnt = 0;
  end
  always @(negedge clk) begin
    if (bus.O_res_dv0) res0_cnt <= res0_cnt + 1;
    if (bus.O_res_dv1) res1_cnt <= res1_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] pat(input int ch, input int k);
    return {32'(ch), 32'(k), 32'hC0DE_0000 ^ 32'(k * 3), 32'h1234_5678 + 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.I_start = 1'b0;
    bus.I_req0  = 1'b0;
    bus.I_req1  = 1'b0;
    bus.I_dv0   = 1'b0;
    bus.I_dv1   = 1'b0;
    bus.I_data0 = '0;
    bus.I_data1 = '0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt0"},     bus.O_gnt0, 0);
    chk({tag, "_gnt1"},     bus.O_gnt1, 0);
    chk({tag, "_busy"},     bus.O_busy, 0);
    chk({tag, "_err"},      bus.O_err, 0);
    chk({tag, "_dp_dv"},    bus.O_dp_dv, 0);
    chk({tag, "_dp_data"},  bus.O_dp_data, 0);
    chk({tag, "_res_dv0"},  bus.O_res_dv0, 0);
    chk({tag, "_res_dv1"},  bus.O_res_dv1, 0);
    chk({tag, "_res_data"}, bus.O_res_data, 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    arst_n   = 1'b1;
    clear_inputs();
    #2;
    arst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    arst_n = 1'b1;

    // Single requester, back-to-back beats through the inverter.
    b0 = res0_cnt;
    bus.I_start = 1'b1;
    bus.I_req0  = 1'b1;
    tick();
    chk("t1_gnt0", bus.O_gnt0, 1);
    chk("t1_gnt1", bus.O_gnt1, 0);
    chk("t1_busy", bus.O_busy, 1);
    bus.I_req0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.I_dv0   = 1'b1;
      bus.I_data0 = pat(0, k);
      tick();
      chk("t1_dp_dv", bus.O_dp_dv, 1);
      chk("t1_dp_data", bus.O_dp_data, pat(0, k));
      chk("t1_gnt0_hold", bus.O_gnt0, 128'(k < 15));
      if (k >= 2) begin
        chk("t1_res_dv0", bus.O_res_dv0, 1);
        chk("t1_res_data", bus.O_res_data, ~pat(0, k - 2));
      end else begin
        chk("t1_res_dv0_early", bus.O_res_dv0, 0);
      end
    end
    bus.I_dv0 = 1'b0;
    tick();
    chk("t1_dp_dv_idle", bus.O_dp_dv, 0);
    chk("t1_dp_hold", bus.O_dp_data, pat(0, 15));
    chk("t1_res_14", bus.O_res_data, ~pat(0, 14));
    tick();
    chk("t1_res_15", bus.O_res_data, ~pat(0, 15));
    chk("t1_res_dv1", bus.O_res_dv1, 0);
    tick();
    chk("t1_res_dv0_end", bus.O_res_dv0, 0);
    chk("t1_busy_end", bus.O_busy, 0);
    chk("t1_err", bus.O_err, 0);
    chk("t1_res_count", 128'(res0_cnt - b0), 16);

    // Both channels requesting: ch0, gap, ch1, gap, ch0.
    do_reset();
    b0 = res0_cnt;
    b1 = res1_cnt;
    bus.I_start = 1'b1;
    bus.I_req0  = 1'b1;
    bus.I_req1  = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      tick();
      eg0 = ((c >= 1) && (c <= 16)) || ((c >= 35) && (c <= 50));
      eg1 = (c >= 18) && (c <= 33);
      chk($sformatf("t2_gnt0_c%0d", c), bus.O_gnt0, 128'(eg0));
      chk($sformatf("t2_gnt1_c%0d", c), bus.O_gnt1, 128'(eg1));
      bus.I_dv0   = eg0;
      bus.I_dv1   = eg1;
      bus.I_data0 = pat(0, c);
      bus.I_data1 = pat(1, c);
      if (c == 40) bus.I_start = 1'b0;
    end
    bus.I_dv0 = 1'b0;
    bus.I_dv1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t2_no_gnt_stopped", 128'({bus.O_gnt1, bus.O_gnt0}), 0);
    end
    chk("t2_res0_count", 128'(res0_cnt - b0), 32);
    chk("t2_res1_count", 128'(res1_cnt - b1), 16);
    chk("t2_err", bus.O_err, 0);

    // Gapped beats on ch0: grant held until the 16th accepted beat.
    do_reset();
    b0 = res0_cnt;
    last_dp = '0;
    bus.I_start = 1'b1;
    bus.I_req0  = 1'b1;
    tick();
    bus.I_req0 = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      chk($sformatf("t3_gnt0_c%0d", c), bus.O_gnt0, 128'(c <= 31));
      drv = ((c % 2) == 1) && (c <= 31);
      bus.I_dv0   = drv;
      bus.I_data0 = pat(0, c);
      tick();
      chk("t3_dp_dv", bus.O_dp_dv, 128'(drv));
      if (drv) last_dp = pat(0, c);
      chk("t3_dp_data", bus.O_dp_data, last_dp);
    end
    bus.I_dv0 = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_res_count", 128'(res0_cnt - b0), 16);
    chk("t3_err", bus.O_err, 0);

    // Beat on the ungranted channel is dropped and sets the sticky error.
    do_reset();
    bus.I_start = 1'b1;
    bus.I_req0  = 1'b1;
    tick();
    chk("t4_gnt0", bus.O_gnt0, 1);
    bus.I_req0  = 1'b0;
    bus.I_dv1   = 1'b1;
    bus.I_data1 = pat(1, 99);
    tick();
    chk("t4_dropped_dv", bus.O_dp_dv, 0);
    chk("t4_dropped_data", bus.O_dp_data, 0);
    chk("t4_err_set", bus.O_err, 1);
    bus.I_dv1   = 1'b0;
    bus.I_dv0   = 1'b1;
    bus.I_data0 = pat(0, 7);
    tick();
    chk("t4_ok_dv", bus.O_dp_dv, 1);
    chk("t4_ok_data", bus.O_dp_data, pat(0, 7));
    bus.I_dv0 = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_err_sticky", bus.O_err, 1);

    // I_start dropped mid ch1 burst with ch0 waiting.
    do_reset();
    chk("t5_err_cleared", bus.O_err, 0);
    b1 = res1_cnt;
    bus.I_start = 1'b1;
    bus.I_req1  = 1'b1;
    tick();
    chk("t5_gnt1", bus.O_gnt1, 1);
    chk("t5_gnt0", bus.O_gnt0, 0);
    bus.I_req1 = 1'b0;
    bus.I_req0 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.I_dv1   = 1'b1;
      bus.I_data1 = pat(1, k);
      tick();
      if (k == 4) bus.I_start = 1'b0;
      chk("t5_gnt1_hold", bus.O_gnt1, 128'(k < 15));
    end
    bus.I_dv1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_no_gnt0", bus.O_gnt0, 0);
    end
    chk("t5_res1_count", 128'(res1_cnt - b1), 16);
    chk("t5_err", bus.O_err, 0);
    bus.I_start = 1'b1;
    tick();
    chk("t5_gnt0_restart", bus.O_gnt0, 1);

    // Asynchronous reset at beat 8, then a clean ch1 burst.
    do_reset();
    bus.I_start = 1'b1;
    bus.I_req0  = 1'b1;
    tick();
    bus.I_req0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.I_dv0   = 1'b1;
      bus.I_data0 = pat(0, k + 40);
      tick();
    end
    chk("t6_pre_busy", bus.O_busy, 1);
    arst_n    = 1'b0;
    bus.I_dv0 = 1'b0;
    #1;
    chk_all_zero("t6_async");
    tick();
    arst_n      = 1'b1;
    bus.I_req1  = 1'b1;
    b1 = res1_cnt;
    tick();
    chk("t6_gnt1", bus.O_gnt1, 1);
    chk("t6_gnt0", bus.O_gnt0, 0);
    bus.I_req1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.I_dv1   = 1'b1;
      bus.I_data1 = pat(1, k + 60);
      tick();
      chk("t6_gnt1_hold", bus.O_gnt1, 128'(k < 15));
    end
    bus.I_dv1 = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_busy_end", bus.O_busy, 0);
    chk("t6_res1_count", 128'(res1_cnt - b1), 16);
    chk("t6_last_res", bus.O_res_data, ~pat(1, 75));
    chk("t6_err", bus.O_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
